page_transfer_controller: RTL

Moves 256-bit rows between word-wide main memory and a processor core's local-memory row port.
- Inbound: on a load command, reads one 256-word main page as 16 rows of 16 words. Each row is packed and delivered with a one-cycle write_page_in pulse at the row's page_offset.
- Outbound: accepts rows offered by the core (write_page_out_ready) and writes each one back to main memory word by word.
- Sits directly between the core's page ports and the main-memory bus.

---
 rtl/page_transfer_controller_pkg.sv | 41 ++++
 rtl/page_transfer_controller_if.sv | 34 +++
 rtl/page_transfer_controller_row_buffer.sv | 38 +++
 rtl/page_transfer_controller.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/page_transfer_controller_pkg.sv
// Shared definitions for the page transfer controller.
// Row/page geometry, address layout and FSM states.
package page_defs;

  localparam int WORDS_PER_ROW  = 16;
  localparam int ROWS_PER_PAGE  = 16;
  localparam int ROW_WORDS      = WORDS_PER_ROW;
  localparam int PAGE_ROWS      = ROWS_PER_PAGE;

  localparam int WORD_W  = 16;
  localparam int ROW_W   = ROW_WORDS * WORD_W;

  localparam int PAGE_AW  = 32;
  localparam int ROW_AW   = 4;
  localparam int WORD_AW  = 4;
  localparam int LOCAL_AW = 8;

  localparam int MEM_ADDR_WIDTH = PAGE_AW + ROW_AW + WORD_AW;

  typedef enum logic [2:0] {
    IDLE,
    LD_READ,
    LD_DELIVER,
    ST_WRITE,
    ST_ACCEPT
  } xfer_state_t;

  typedef struct packed {
    logic [PAGE_AW-1:0]  main_page;
    logic [LOCAL_AW-1:0] local_page;
  } load_cmd_t;

  function automatic logic [MEM_ADDR_WIDTH-1:0] word_addr(
    input logic [PAGE_AW-1:0] page,
    input logic [ROW_AW-1:0]  row,
    input logic [WORD_AW-1:0] word
  );
    return {page, row, word};
  endfunction

endpackage

// File: rtl/page_transfer_controller_if.sv
// Word-wide main-memory bus: one request outstanding,
// read held until valid, write held until ack.
interface page_transfer_controller_if;
  import page_defs::*;

  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_read_req;
  logic                      mem_read_valid;
  logic [WORD_W-1:0]         mem_read_data;
  logic                      mem_write_req;
  logic [WORD_W-1:0]         mem_write_data;
  logic                      mem_write_ack;

  modport master (
    output mem_addr,
    output mem_read_req,
    input  mem_read_valid,
    input  mem_read_data,
    output mem_write_req,
    output mem_write_data,
    input  mem_write_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_read_req,
    output mem_read_valid,
    output mem_read_data,
    input  mem_write_req,
    input  mem_write_data,
    output mem_write_ack
  );

endinterface

// File: rtl/page_transfer_controller_row_buffer.sv
// 16x16-bit row register: whole-row load, per-word write,
// per-word read mux. Shared by load and store paths.
module row_buffer_16x16
  import page_defs::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_en,
  input  logic [ROW_W-1:0]   load_row,
  input  logic               wr_en,
  input  logic [WORD_AW-1:0] wr_idx,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic [WORD_AW-1:0] rd_idx,
  output logic [ROW_W-1:0]   row,
  output logic [WORD_W-1:0]  rd_data
);

  logic [ROW_W-1:0] row_q;
  logic [7:0]       wr_base;
  logic [7:0]       rd_base;

  assign wr_base = {wr_idx, 4'h0};
  assign rd_base = {rd_idx, 4'h0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q <= '0;
    end else if (load_en) begin
      row_q <= load_row;
    end else if (wr_en) begin
      row_q[wr_base +: WORD_W] <= wr_data;
    end
  end

  assign row     = row_q;
  assign rd_data = row_q[rd_base +: WORD_W];

endmodule

// File: rtl/page_transfer_controller.sv
// Moves 256-bit rows between word-wide main memory
// and the core's local-memory row port.
module page_transfer_controller
  import page_defs::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load_start,
  input  logic [PAGE_AW-1:0]  load_main_page,
  input  logic [LOCAL_AW-1:0] load_local_page,
  output logic                busy,
  output logic                load_done,
  output logic [LOCAL_AW-1:0] local_page_in,
  output logic [ROW_AW-1:0]   page_offset,
  output logic [ROW_W-1:0]    page_data,
  output logic                write_page_in,
  input  logic                write_page_out_ready,
  input  logic [LOCAL_AW-1:0] local_page_out,
  input  logic [PAGE_AW-1:0]  main_page_out,
  input  logic [ROW_W-1:0]    page_data_out,
  output logic                write_page_out_accepted,
  page_transfer_controller_if.master mem
);

  xfer_state_t         state_q, state_d;
  load_cmd_t           ld_q, ld_d;
  logic [PAGE_AW-1:0]  st_page_q, st_page_d;
  logic [ROW_AW-1:0]   row_q, row_d;
  logic [WORD_AW-1:0]  word_q, word_d;
  logic [ROW_AW-1:0]   out_row_q, out_row_d;

  logic [ROW_W-1:0]    pd_q;
  logic [ROW_AW-1:0]   off_q;
  logic [LOCAL_AW-1:0] lpi_q;

  logic                buf_load;
  logic                buf_wr;
  logic [ROW_W-1:0]    buf_row;
  logic [WORD_W-1:0]   buf_word;

  logic                rd_req;
  logic                wr_req;
  logic                strobe;

  logic                unused_local_page;
  assign unused_local_page = ^local_page_out;

  row_buffer_16x16 u_buf (
    .clock    (clock),
    .reset    (reset),
    .load_en  (buf_load),
    .load_row (page_data_out),
    .wr_en    (buf_wr),
    .wr_idx   (word_q),
    .wr_data  (mem.mem_read_data),
    .rd_idx   (word_q),
    .row      (buf_row),
    .rd_data  (buf_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ld_q      <= '0;
      st_page_q <= '0;
      row_q     <= '0;
      word_q    <= '0;
      out_row_q <= '0;
      pd_q      <= '0;
      off_q     <= '0;
      lpi_q     <= '0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      st_page_q <= st_page_d;
      row_q     <= row_d;
      word_q    <= word_d;
      out_row_q <= out_row_d;
      if (strobe) begin
        pd_q  <= buf_row;
        off_q <= row_q;
        lpi_q <= ld_q.local_page;
      end
    end
  end

  // Store offers win over load commands in the same idle cycle.
  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    st_page_d = st_page_q;
    row_d     = row_q;
    word_d    = word_q;
    out_row_d = out_row_q;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_page_out_ready) begin
          st_page_d = main_page_out;
          word_d    = '0;
          buf_load  = 1'b1;
          state_d   = ST_WRITE;
        end else if (load_start) begin
          ld_d.main_page  = load_main_page;
          ld_d.local_page = load_local_page;
          row_d           = '0;
          word_d          = '0;
          state_d         = LD_READ;
        end
      end
      LD_READ: begin
        if (mem.mem_read_valid) begin
          buf_wr = 1'b1;
          word_d = word_q + 4'd1;
          if (word_q == 4'hF) begin
            state_d = LD_DELIVER;
          end
        end
      end
      LD_DELIVER: begin
        if (row_q == 4'hF) begin
          state_d = IDLE;
        end else begin
          row_d   = row_q + 4'd1;
          word_d  = '0;
          state_d = LD_READ;
        end
      end
      ST_WRITE: begin
        if (mem.mem_write_ack) begin
          word_d = word_q + 4'd1;
          if (word_q == 4'hF) begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        out_row_d = out_row_q + 4'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_req = (state_q == LD_READ);
  assign wr_req = (state_q == ST_WRITE);
  assign strobe = (state_q == LD_DELIVER);

  assign busy                    = (state_q != IDLE);
  assign write_page_in           = strobe;
  assign load_done               = strobe && (row_q == 4'hF);
  assign write_page_out_accepted = (state_q == ST_ACCEPT);

  // Row port shows the live buffer on the strobe, else the last row.
  assign page_data     = strobe ? buf_row : pd_q;
  assign page_offset   = strobe ? row_q : off_q;
  assign local_page_in = strobe ? ld_q.local_page : lpi_q;

  always_comb begin
    mem.mem_addr = '0;
    unique case (1'b1)
      rd_req: mem.mem_addr =
        word_addr(ld_q.main_page, row_q, word_q);
      wr_req: mem.mem_addr =
        word_addr(st_page_q, out_row_q, word_q);
      default: mem.mem_addr = '0;
    endcase
  end

  assign mem.mem_read_req   = rd_req;
  assign mem.mem_write_req  = wr_req;
  assign mem.mem_write_data = buf_word;

endmodule
